// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction fetch front end for the MIPS core. Owns the fetch PC, requests
// words from program memory over a valid/ready handshake and buffers them in
// a small FIFO. The head entry is presented to the control decoder and
// datapath. A one-cycle redirect from branch resolution flushes the buffer
// and restarts fetch at the new target.
//
// Optional feature: define FETCH_BYPASS_EN to let a word fetched into an
// empty buffer go straight to the issue outputs in the same cycle when the
// consumer is ready. Without it, every word passes through the FIFO and
// there is no combinational path from imem_* to the issue outputs.
//
// Parameters:
//   RESET_PC    fetch address loaded on reset (word aligned)
//   FIFO_DEPTH  instruction buffer entries (power of two, 2..8)
//
// Ports:
//   clk            core clock, rising edge
//   reset          asynchronous active-low reset
//   imem_req       fetch request valid (registered state only)
//   imem_addr      word-aligned fetch address
//   imem_ready     memory accepts request, imem_rdata valid same cycle
//   imem_rdata     fetched instruction word
//   redirect_valid one-cycle PC redirect
//   redirect_pc    redirect target, bits [1:0] ignored
//   issue_valid    head instruction valid
//   issue_ready    consumer takes the head this cycle
//   Instruction    head instruction word, zero (NOP) when not valid
//   OP             Instruction[31:26]
//   PC_out         address of head instruction, zero when not valid
//   PC_4           PC_out + 4, zero when not valid
// ----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0040_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        issue_valid,
    input  logic        issue_ready,
    output logic [31:0] Instruction,
    output logic [5:0]  OP,
    output logic [31:0] PC_out,
    output logic [31:0] PC_4
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {StBoot, StFetch, StFull} stateT;

    stateT            stateQ, stateD;
    logic [31:0]      fetchPcQ, fetchPcD;
    logic [CntW-1:0]  countQ, countD;
    logic [PtrW-1:0]  rdPtrQ, rdPtrD;
    logic [PtrW-1:0]  wrPtrQ, wrPtrD;

    logic [31:0]      instrMem [FIFO_DEPTH];
    logic [31:0]      pcMem    [FIFO_DEPTH];

    logic             transfer;
    logic             redirectEn;
    logic             fifoEmpty;
    logic             bypass;
    logic             push;
    logic             popFifo;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    assign transfer   = imem_req && imem_ready;
    // Redirects arriving before the first fetch are dropped.
    assign redirectEn = redirect_valid && (stateQ != StBoot);
    assign fifoEmpty  = (countQ == '0);

`ifdef FETCH_BYPASS_EN
    assign bypass = fifoEmpty && transfer && issue_ready && !redirectEn;
`else
    assign bypass = 1'b0;
`endif

    // A redirected transfer is still acknowledged, its data is dropped.
    assign push    = transfer && !redirectEn && !bypass;
    assign popFifo = !fifoEmpty && issue_ready;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ <= StBoot;
        end else begin
            stateQ <= stateD;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StBoot:  stateD = StFetch;
            StFetch: if (countD == CntW'(FIFO_DEPTH)) stateD = StFull;
            StFull:  if (popFifo) stateD = StFetch;
            default: stateD = StBoot;
        endcase
        if (redirectEn) begin
            stateD = StFetch;
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs (registered state only, no path from issue_ready)
    // ------------------------------------------------------------------
    always_comb begin
        imem_req = (stateQ == StFetch);
    end

    assign imem_addr = fetchPcQ;

    // ------------------------------------------------------------------
    // Fetch PC and FIFO bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        fetchPcD = fetchPcQ;
        countD   = countQ;
        rdPtrD   = rdPtrQ;
        wrPtrD   = wrPtrQ;
        if (redirectEn) begin
            fetchPcD = redirect_pc & 32'hFFFF_FFFC;
            countD   = '0;
            rdPtrD   = '0;
            wrPtrD   = '0;
        end else begin
            if (transfer) begin
                fetchPcD = fetchPcQ + 32'd4;
            end
            if (push) begin
                wrPtrD = wrPtrQ + PtrW'(1);
            end
            if (popFifo) begin
                rdPtrD = rdPtrQ + PtrW'(1);
            end
            countD = countQ + CntW'(push) - CntW'(popFifo);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetchPcQ <= RESET_PC;
            countQ   <= '0;
            rdPtrQ   <= '0;
            wrPtrQ   <= '0;
        end else begin
            fetchPcQ <= fetchPcD;
            countQ   <= countD;
            rdPtrQ   <= rdPtrD;
            wrPtrQ   <= wrPtrD;
        end
    end

    // Storage needs no reset: outputs are masked whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            instrMem[wrPtrQ] <= imem_rdata;
            pcMem[wrPtrQ]    <= fetchPcQ;
        end
    end

    // ------------------------------------------------------------------
    // Issue outputs
    // ------------------------------------------------------------------
    assign issue_valid = !fifoEmpty || bypass;

    always_comb begin
        Instruction = 32'h0000_0000;
        PC_out      = 32'h0000_0000;
        if (bypass) begin
            Instruction = imem_rdata;
            PC_out      = fetchPcQ;
        end else if (!fifoEmpty) begin
            Instruction = instrMem[rdPtrQ];
            PC_out      = pcMem[rdPtrQ];
        end
    end

    assign OP   = Instruction[31:26];
    assign PC_4 = issue_valid ? (PC_out + 32'd4) : 32'h0000_0000;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC   = 32'h0040_0000;
    localparam int unsigned FIFO_DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        issue_valid;
    logic        issue_ready;
    logic [31:0] Instruction;
    logic [5:0]  OP;
    logic [31:0] PC_out;
    logic [31:0] PC_4;

    int          nVectors     = 0;
    int          nMiscompares = 0;

    // Scoreboard entries are {pc, word}.
    logic [63:0] sbQueue [$];
    logic [31:0] expPc;
    bit          inBoot;
    int          xferCount;

    instr_fetch_unit #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .Instruction    (Instruction),
        .OP             (OP),
        .PC_out         (PC_out),
        .PC_4           (PC_4)
    );

    always #5 clk = ~clk;

    // Program memory: word derived from its address so order errors show up.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[7:2], a[27:2]} ^ 32'h1234_5678;
    endfunction

    assign imem_rdata = memWord(imem_addr);

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVectors++;
        if (obs !== exp) begin
            nMiscompares++;
            $display("FAIL %s: observed %08h, expected %08h", tag, obs, exp);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkEq({tag, ".imem_req"},    {31'b0, imem_req},    32'd0);
        checkEq({tag, ".imem_addr"},   imem_addr,            RESET_PC);
        checkEq({tag, ".issue_valid"}, {31'b0, issue_valid}, 32'd0);
        checkEq({tag, ".Instruction"}, Instruction,          32'd0);
        checkEq({tag, ".OP"},          {26'b0, OP},          32'd0);
        checkEq({tag, ".PC_out"},      PC_out,               32'd0);
        checkEq({tag, ".PC_4"},        PC_4,                 32'd0);
    endtask

    // One clock cycle: drive inputs just after the falling edge, check outputs
    // against the model, advance the model across the rising edge.
    task automatic runCycle(input logic rdy, input logic irdy, input logic redir,
                            input logic [31:0] target);
        logic [63:0] head;
        logic        expReq;
        logic        expValid;
        imem_ready     = rdy;
        issue_ready    = irdy;
        redirect_valid = redir;
        redirect_pc    = target;
        #1;
        expReq   = !inBoot && (sbQueue.size() < int'(FIFO_DEPTH));
        expValid = (sbQueue.size() != 0);
        checkEq("imem_req", {31'b0, imem_req}, {31'b0, expReq});
        if (expReq) begin
            checkEq("imem_addr", imem_addr, expPc);
        end
        checkEq("issue_valid", {31'b0, issue_valid}, {31'b0, expValid});
        if (!expValid) begin
            checkEq("nop_instr", Instruction, 32'd0);
            checkEq("nop_pc", PC_out, 32'd0);
        end else if (irdy) begin
            head = sbQueue.pop_front();
            checkEq("instr", Instruction, head[31:0]);
            checkEq("pc_out", PC_out, head[63:32]);
            checkEq("op", {26'b0, OP}, {26'b0, head[31:26]});
            checkEq("pc_4", PC_4, head[63:32] + 32'd4);
        end
        if (redir && !inBoot) begin
            sbQueue.delete();
            expPc = target & 32'hFFFF_FFFC;
        end else if (expReq && rdy) begin
            sbQueue.push_back({expPc, memWord(expPc)});
            expPc = expPc + 32'd4;
            xferCount++;
        end
        inBoot = 1'b0;
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, nVectors=%0d", nVectors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset          = 1'b0;
        imem_ready     = 1'b0;
        issue_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        xferCount      = 0;
        repeat (2) @(negedge clk);
        checkResetValues("reset");

        // Release and stream at full rate.
        reset  = 1'b1;
        inBoot = 1'b1;
        expPc  = RESET_PC;
        repeat (8) runCycle(1'b1, 1'b1, 1'b0, 32'd0);

        // Drain, then stall the consumer: only FIFO_DEPTH transfers may occur.
        repeat (2) runCycle(1'b0, 1'b1, 1'b0, 32'd0);
        xferCount = 0;
        repeat (6) runCycle(1'b1, 1'b0, 1'b0, 32'd0);
        checkEq("stall_xfers", xferCount, FIFO_DEPTH);
        repeat (6) runCycle(1'b1, 1'b1, 1'b0, 32'd0);

        // Memory ready toggling: address must hold while unacknowledged.
        for (int i = 0; i < 10; i++) begin
            runCycle(((i % 2) == 0) ? 1'b1 : 1'b0, 1'b1, 1'b0, 32'd0);
        end

        // Fill the buffer, then redirect to an unaligned target.
        repeat (4) runCycle(1'b1, 1'b0, 1'b0, 32'd0);
        runCycle(1'b1, 1'b0, 1'b1, 32'h0040_0103);
        #1;
        checkEq("redir_valid", {31'b0, issue_valid}, 32'd0);
        checkEq("redir_addr", imem_addr, 32'h0040_0100);
        repeat (5) runCycle(1'b1, 1'b1, 1'b0, 32'd0);

        // Fetch PC wraps past the top of the address space.
        runCycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
        repeat (6) runCycle(1'b1, 1'b1, 1'b0, 32'd0);

        // Asynchronous reset mid-stream with a non-empty buffer.
        repeat (3) runCycle(1'b1, 1'b0, 1'b0, 32'd0);
        #2;
        reset = 1'b0;
        #1;
        checkResetValues("midreset");
        sbQueue.delete();
        expPc  = RESET_PC;
        inBoot = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        repeat (6) runCycle(1'b1, 1'b1, 1'b0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
